// File: rtl/mem_wb_if.sv
// MEM/WB stage bus: MEM-side instruction fields, pipeline controls,
// WB-side results and the forwarding query port.
interface mem_wb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 1
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic              stall;
  logic              flush;
  logic              valid_MEM;
  logic              write_regf_MEM;
  logic              mem_to_reg_MEM;
  logic [DATA_W-1:0] dmem_rdata_MEM;
  logic [DATA_W-1:0] alu_result_MEM;
  logic [ADDR_W-1:0] waddr_regf_MEM;

  logic              valid_WB;
  logic              write_regf_WB;
  logic              mem_to_reg_WB;
  logic [DATA_W-1:0] dmem_rdata_WB;
  logic [DATA_W-1:0] alu_result_WB;
  logic [ADDR_W-1:0] waddr_regf_WB;
  logic [DATA_W-1:0] wb_data_WB;

  logic [ADDR_W-1:0] fwd_raddr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [OCC_W-1:0]  occupancy;

  modport master (
    output stall, flush, valid_MEM, write_regf_MEM, mem_to_reg_MEM,
           dmem_rdata_MEM, alu_result_MEM, waddr_regf_MEM, fwd_raddr,
    input  valid_WB, write_regf_WB, mem_to_reg_WB, dmem_rdata_WB,
           alu_result_WB, waddr_regf_WB, wb_data_WB, fwd_hit, fwd_data,
           occupancy
  );

  modport slave (
    input  stall, flush, valid_MEM, write_regf_MEM, mem_to_reg_MEM,
           dmem_rdata_MEM, alu_result_MEM, waddr_regf_MEM, fwd_raddr,
    output valid_WB, write_regf_WB, mem_to_reg_WB, dmem_rdata_WB,
           alu_result_WB, waddr_regf_WB, wb_data_WB, fwd_hit, fwd_data,
           occupancy
  );
endinterface

// File: rtl/mem_wb_pipe.sv
// MEM/WB pipeline stage: DEPTH register slots with stall, flush, valid
// tracking, write-back result mux, occupancy count and forwarding lookup.
module mem_wb_pipe #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 1,
  parameter bit ZERO_REG = 1'b1
) (
  input logic   clk,
  input logic   rst,
  mem_wb_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
      $error("mem_wb_pipe: DEPTH must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic              valid;
    logic              write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] waddr;
  } slot_t;

  slot_t             slots [DEPTH];
  slot_t             in_slot;
  slot_t             last;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  occ_adv;

  // Bubbles enter as all-zero slots so WB fields stay 0 until real work arrives.
  always_comb begin
    in_slot = '0;
    if (bus.valid_MEM) begin
      in_slot.valid      = 1'b1;
      in_slot.write      = bus.write_regf_MEM;
      in_slot.mem_to_reg = bus.mem_to_reg_MEM;
      in_slot.rdata      = bus.dmem_rdata_MEM;
      in_slot.alu        = bus.alu_result_MEM;
      in_slot.waddr      = bus.waddr_regf_MEM;
    end
  end

  // Valid count after an advance: new input plus every slot that does not retire.
  always_comb begin
    occ_adv = OCC_W'(bus.valid_MEM);
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      occ_adv = occ_adv + OCC_W'(slots[k].valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slots[k] <= '0;
      end
      occ <= '0;
    end else if (bus.flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        slots[k].valid <= 1'b0;
      end
      occ <= '0;
    end else if (!bus.stall) begin
      slots[0] <= in_slot;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        slots[k] <= slots[k-1];
      end
      occ <= occ_adv;
    end
  end

  assign last = slots[DEPTH-1];

  assign bus.valid_WB      = last.valid;
  assign bus.write_regf_WB = last.valid & last.write &
                             (!ZERO_REG || (last.waddr != '0));
  assign bus.mem_to_reg_WB = last.mem_to_reg;
  assign bus.dmem_rdata_WB = last.rdata;
  assign bus.alu_result_WB = last.alu;
  assign bus.waddr_regf_WB = last.waddr;
  assign bus.wb_data_WB    = last.mem_to_reg ? last.rdata : last.alu;
  assign bus.occupancy     = occ;

  // Ascending scan keeps the first (youngest) match.
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (!bus.fwd_hit && slots[k].valid && slots[k].write &&
          (slots[k].waddr == bus.fwd_raddr) &&
          (!ZERO_REG || (bus.fwd_raddr != '0))) begin
        bus.fwd_hit  = 1'b1;
        bus.fwd_data = slots[k].mem_to_reg ? slots[k].rdata : slots[k].alu;
      end
    end
  end
endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe (DEPTH=3, ZERO_REG=1): accepted
// instructions are queued with their entry time and checked at WB.
module tb_mem_wb_pipe;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 3;

    typedef struct {
        bit                write;
        bit                m2r;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] alu;
        logic [ADDR_W-1:0] waddr;
        int unsigned       adv_at;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned adv_cnt  = 0;
    bit obs_on = 1'b0;
    entry_t sb [$];

    mem_wb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    mem_wb_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare current outputs against the scoreboard view of the pipeline.
    task automatic observe();
        bit                exp_v;
        bit                exp_hit;
        logic [DATA_W-1:0] exp_fd;
        entry_t            h;
        exp_v = (sb.size() > 0) && (adv_cnt - sb[0].adv_at == DEPTH - 1);
        check_eq("valid_WB", 64'(bus.valid_WB), 64'(exp_v));
        check_eq("occupancy", 64'(bus.occupancy), 64'(sb.size()));
        if (exp_v) begin
            h = sb[0];
            check_eq("write_regf_WB", 64'(bus.write_regf_WB), 64'(h.write && h.waddr != '0));
            check_eq("mem_to_reg_WB", 64'(bus.mem_to_reg_WB), 64'(h.m2r));
            check_eq("waddr_regf_WB", 64'(bus.waddr_regf_WB), 64'(h.waddr));
            check_eq("wb_data_WB", 64'(bus.wb_data_WB), 64'(h.m2r ? h.rdata : h.alu));
        end else begin
            check_eq("write_regf_WB idle", 64'(bus.write_regf_WB), 64'd0);
        end
        exp_hit = 1'b0;
        exp_fd  = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (!exp_hit && sb[i].write && sb[i].waddr == bus.fwd_raddr && bus.fwd_raddr != '0) begin
                exp_hit = 1'b1;
                exp_fd  = sb[i].m2r ? sb[i].rdata : sb[i].alu;
            end
        end
        check_eq("fwd_hit", 64'(bus.fwd_hit), 64'(exp_hit));
        check_eq("fwd_data", 64'(bus.fwd_data), 64'(exp_fd));
    endtask

    // One cycle: observe, update the model for the coming edge, then move past it.
    task automatic tick();
        entry_t e;
        bit     at_wb;
        #1;
        if (obs_on) observe();
        if (rst || bus.flush) begin
            sb.delete();
        end else if (!bus.stall) begin
            at_wb = (sb.size() > 0) && (adv_cnt - sb[0].adv_at == DEPTH - 1);
            if (at_wb) void'(sb.pop_front());
            adv_cnt++;
            if (bus.valid_MEM) begin
                e.write  = bus.write_regf_MEM;
                e.m2r    = bus.mem_to_reg_MEM;
                e.rdata  = bus.dmem_rdata_MEM;
                e.alu    = bus.alu_result_MEM;
                e.waddr  = bus.waddr_regf_MEM;
                e.adv_at = adv_cnt;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input bit v, input bit w, input bit m,
                          input logic [DATA_W-1:0] rd, input logic [DATA_W-1:0] al,
                          input logic [ADDR_W-1:0] wa);
        bus.valid_MEM      = v;
        bus.write_regf_MEM = w;
        bus.mem_to_reg_MEM = m;
        bus.dmem_rdata_MEM = rd;
        bus.alu_result_MEM = al;
        bus.waddr_regf_MEM = wa;
    endtask

    task automatic issue(input bit w, input bit m, input logic [DATA_W-1:0] rd,
                         input logic [DATA_W-1:0] al, input logic [ADDR_W-1:0] wa);
        set_in(1'b1, w, m, rd, al, wa);
        tick();
    endtask

    task automatic bubbles(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom, ADDR_W'($urandom));
            tick();
        end
    endtask

    task automatic rand_inputs();
        set_in(1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
               ADDR_W'($urandom_range(0, 7)));
        bus.fwd_raddr = ADDR_W'($urandom_range(0, 7));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            bus.stall = 1'($urandom);
            bus.flush = 1'($urandom);
            tick();
            obs_on = 1'b1;
        end
        #1;
        check_eq("rst valid_WB", 64'(bus.valid_WB), 64'd0);
        check_eq("rst write_regf_WB", 64'(bus.write_regf_WB), 64'd0);
        check_eq("rst mem_to_reg_WB", 64'(bus.mem_to_reg_WB), 64'd0);
        check_eq("rst dmem_rdata_WB", 64'(bus.dmem_rdata_WB), 64'd0);
        check_eq("rst alu_result_WB", 64'(bus.alu_result_WB), 64'd0);
        check_eq("rst waddr_regf_WB", 64'(bus.waddr_regf_WB), 64'd0);
        check_eq("rst wb_data_WB", 64'(bus.wb_data_WB), 64'd0);
        check_eq("rst fwd_data", 64'(bus.fwd_data), 64'd0);
        check_eq("rst occupancy", 64'(bus.occupancy), 64'd0);

        // Release reset while stalled: nothing may enter.
        rst = 1'b0;
        bus.stall = 1'b1;
        bus.flush = 1'b0;
        bus.fwd_raddr = 5'd3;
        issue(1'b1, 1'b0, 32'h0, 32'h1234, 5'd3);
        bus.stall = 1'b0;
        bubbles(1);
        check_eq("post-rst stall empty", 64'(bus.occupancy), 64'd0);

        // First instruction; latency checked by the scoreboard.
        issue(1'b1, 1'b0, 32'h0, 32'h1234, 5'd3);
        bubbles(DEPTH - 1);
        check_eq("first wb_data", 64'(bus.wb_data_WB), 64'h1234);
        check_eq("first write_regf_WB", 64'(bus.write_regf_WB), 64'd1);
        bubbles(1);

        // Result mux.
        issue(1'b1, 1'b1, 32'hDEADBEEF, 32'h5, 5'd4);
        issue(1'b1, 1'b0, 32'hDEADBEEF, 32'h5, 5'd4);
        bubbles(DEPTH);

        // Stall mid-stream: A, B, then C held for two stalled cycles.
        issue(1'b1, 1'b0, 32'h0, 32'hA, 5'd1);
        issue(1'b1, 1'b0, 32'h0, 32'hB, 5'd2);
        bus.stall = 1'b1;
        issue(1'b1, 1'b0, 32'h0, 32'hC, 5'd3);
        issue(1'b1, 1'b0, 32'h0, 32'hC, 5'd3);
        bus.stall = 1'b0;
        issue(1'b1, 1'b0, 32'h0, 32'hC, 5'd3);
        bubbles(DEPTH + 1);

        // Forwarding: older load r7=0x22, younger alu r7=0x11.
        bus.fwd_raddr = 5'd7;
        issue(1'b1, 1'b1, 32'h22, 32'h99, 5'd7);
        issue(1'b1, 1'b0, 32'h77, 32'h11, 5'd7);
        #1;
        check_eq("fwd youngest hit", 64'(bus.fwd_hit), 64'd1);
        check_eq("fwd youngest data", 64'(bus.fwd_data), 64'h11);
        bubbles(DEPTH);
        bus.fwd_raddr = 5'd0;
        issue(1'b1, 1'b0, 32'h0, 32'h55, 5'd0);
        bubbles(DEPTH);

        // Flush with stall and a valid input, three slots full.
        bus.fwd_raddr = 5'd2;
        issue(1'b1, 1'b0, 32'h0, 32'h101, 5'd1);
        issue(1'b1, 1'b0, 32'h0, 32'h102, 5'd2);
        issue(1'b1, 1'b0, 32'h0, 32'h103, 5'd3);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        issue(1'b1, 1'b0, 32'h0, 32'h104, 5'd2);
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        #1;
        check_eq("flush valid_WB", 64'(bus.valid_WB), 64'd0);
        check_eq("flush occupancy", 64'(bus.occupancy), 64'd0);
        check_eq("flush fwd_hit", 64'(bus.fwd_hit), 64'd0);
        bubbles(1);

        // Alternating bubbles.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) issue(1'($urandom), 1'($urandom), $urandom, $urandom, ADDR_W'($urandom_range(0, 7)));
            else bubbles(1);
        end
        bubbles(DEPTH);

        // Random traffic with occasional stall and flush.
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            bus.stall = ($urandom_range(0, 4) == 0);
            bus.flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bubbles(DEPTH + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_wb_pipe.md
# mem_wb_pipe

Parametrised MEM/WB pipeline stage: a DEPTH-deep chain of register slots carrying the write-back control bits, load data, ALU result and destination register address from MEM to WB. It adds stall, flush, per-slot valid tracking, a write-back result mux, an occupancy counter and a combinational forwarding lookup across all in-flight slots. It sits between the data-memory stage and the register-file write port.

## Interface
- DATA_W, 32, width of load data and ALU result
- ADDR_W, 5, register-file address width
- DEPTH, 1, number of register slots (legal 1..4)
- ZERO_REG, 1, when 1, address 0 never forwards and never asserts write_regf_WB
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  hold all slots
- flush  in  1  invalidate all slots
- valid_MEM  in  1  incoming instruction is real (0 = bubble)
- write_regf_MEM  in  1  register-file write enable
- mem_to_reg_MEM  in  1  select load data (1) or ALU result (0)
- dmem_rdata_MEM  in  DATA_W  load data
- alu_result_MEM  in  DATA_W  ALU result
- waddr_regf_MEM  in  ADDR_W  destination register
- valid_WB  out  1  last slot holds a real instruction
- write_regf_WB  out  1  valid_WB & stored write enable (& waddr≠0 when ZERO_REG)
- mem_to_reg_WB, dmem_rdata_WB, alu_result_WB, waddr_regf_WB  out  1/DATA_W/DATA_W/ADDR_W  last-slot fields
- wb_data_WB  out  DATA_W  mem_to_reg_WB ? dmem_rdata_WB : alu_result_WB
- fwd_raddr  in  ADDR_W  forwarding query address
- fwd_hit  out  1  some valid slot writes fwd_raddr
- fwd_data  out  DATA_W  selected result of the youngest matching slot
- occupancy  out  $clog2(DEPTH+1)  count of valid slots, registered

## Operation
- Slots S0 (youngest) .. S[DEPTH-1] (oldest, drives *_WB outputs). Each slot: valid, write, mem_to_reg, rdata, alu, waddr.
- Per-edge priority: rst > flush > stall > advance.
- rst: every slot field cleared to 0; occupancy 0.
- flush: every valid bit cleared; data fields may keep stale values; occupancy 0. Flush overrides stall.
- stall (no flush): all slots hold; the MEM input is dropped (upstream holds it).
- advance: S0 ← MEM inputs (valid = valid_MEM), Sk ← S[k-1]; the old S[DEPTH-1] retires.
- Bubbles (valid 0) propagate as slots; their write/fwd effects are masked.
- occupancy next = popcount of next-state valid bits; it must equal the popcount of the current valid bits at all times.
- Forwarding (combinational): slot matches if valid & write & waddr == fwd_raddr (& fwd_raddr≠0 when ZERO_REG). The youngest match (lowest index) wins. fwd_data = that slot's mem_to_reg ? rdata : alu. On no match: fwd_hit 0, fwd_data 0.
- Forwarding looks only at slots, never at the MEM inputs.
- DEPTH=1 behaves as the plain MEM/WB register plus valid, stall and flush.

## Timing
- Latency MEM→WB: exactly DEPTH rising edges with no stall; each stall cycle adds one.
- Throughput: one instruction per non-stalled cycle.
- All *_WB outputs, wb_data_WB, fwd_hit and fwd_data are 0 during and after reset until the first real instruction reaches them.
- write_regf_WB is combinational from S[DEPTH-1] (and ADDR gating); no extra register stage.
- A flush asserted together with valid_MEM=1 discards that instruction.
- Deassertion of rst with stall=1: the slots stay empty and valid_WB stays 0.
- DEPTH outside 1..4: elaboration error.

## Test plan
- Reset: drive random inputs with rst=1 for 3 cycles → all outputs 0, occupancy 0; release, valid_MEM=1, alu=0x1234, waddr=3, write=1, DEPTH=2 → valid_WB and write_regf_WB rise 2 edges later, wb_data_WB=0x1234.
- Result mux: mem_to_reg=1, rdata=0xDEADBEEF, alu=0x5 → wb_data_WB=0xDEADBEEF; mem_to_reg=0 → 0x5.
- Stall: DEPTH=3, issue A,B,C, stall 2 cycles mid-stream → order A,B,C preserved at WB, each delayed 2 cycles, no duplicates, occupancy steady during stall.
- Flush: 3 valid slots, flush=1 with stall=1 and valid_MEM=1 → next cycle valid_WB=0, occupancy 0, fwd_hit 0.
- Forwarding: S0 writes r7=0x11 (alu), S1 writes r7=0x22 (load), query r7 → fwd_hit 1, fwd_data 0x11; query r0 with a slot writing r0 under ZERO_REG=1 → fwd_hit 0, write_regf_WB 0 when it retires.
- Bubbles: alternate valid_MEM 1/0 for 10 cycles → occupancy toggles per popcount, write_regf_WB asserted only for valid entries.
